// File: rtl/shift_pulse_driver.sv
// shift_pulse_driver: times up/down shift solenoid pulses with a post-pulse holdoff.
// Define SHIFT_DROP_CNT_EN to add drop_count, a saturating count of requests dropped while busy.
module shift_pulse_driver #(
  parameter int CNT_W          = 32,
  parameter int NORMAL_CYCLES  = 5000000,
  parameter int NEUTRAL_CYCLES = 2500000,
  parameter int HOLDOFF_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       up_req,
  input  logic       down_req,
  input  logic       half,
  input  logic       abort,
  output logic       up_out,
  output logic       down_out,
  output logic       busy,
  output logic       done,
  output logic       conflict
`ifdef SHIFT_DROP_CNT_EN
  ,
  output logic [7:0] drop_count
`endif
);
  if ((NORMAL_CYCLES >> CNT_W) != 0 || (NEUTRAL_CYCLES >> CNT_W) != 0 ||
      (HOLDOFF_CYCLES >> CNT_W) != 0) begin : g_len_check
    $error("shift_pulse_driver: a cycle length does not fit in CNT_W bits");
  end
  // zero-length pulses are stretched to one cycle
  localparam logic [CNT_W-1:0] NORM_L = CNT_W'(NORMAL_CYCLES == 0 ? 1 : NORMAL_CYCLES);
  localparam logic [CNT_W-1:0] NEU_L  = CNT_W'(NEUTRAL_CYCLES == 0 ? 1 : NEUTRAL_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(HOLDOFF_CYCLES);
  typedef enum logic [1:0] {IDLE, FIRE_UP, FIRE_DOWN, HOLDOFF} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic done_nx, conflict_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      done     <= done_nx;
      conflict <= conflict_nx;
    end
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    done_nx     = 1'b0;
    conflict_nx = 1'b0;
    case (state)
      IDLE:
        if (up_req && down_req) conflict_nx = 1'b1;
        else if (up_req || down_req) begin
          state_nx = up_req ? FIRE_UP : FIRE_DOWN;
          cnt_nx   = half ? NEU_L : NORM_L;
        end
      FIRE_UP, FIRE_DOWN:
        if (abort || cnt <= CNT_W'(1)) begin
          done_nx  = 1'b1;
          state_nx = HOLDOFF_CYCLES == 0 ? IDLE : HOLDOFF;
          cnt_nx   = HOLD_L;
        end else cnt_nx = cnt - CNT_W'(1);
      HOLDOFF:
        if (cnt <= CNT_W'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else cnt_nx = cnt - CNT_W'(1);
      default: state_nx = IDLE;
    endcase
  end
  // outputs decode straight from the async-reset state register, so reset kills them instantly
  assign up_out   = state == FIRE_UP;
  assign down_out = state == FIRE_DOWN;
  assign busy     = state != IDLE;
`ifdef SHIFT_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_count <= '0;
    else if ((up_req || down_req) && busy && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
`endif
endmodule

// File: tb/tb_shift_pulse_driver.sv
// tb_shift_pulse_driver: directed checks of pulse timing, conflict, drop, abort and async reset.
module tb_shift_pulse_driver;
  logic clk = 1'b0, rst_n = 1'b0;
  logic up_req = 1'b0, down_req = 1'b0, half = 1'b0, abort = 1'b0;
  logic up_out, down_out, busy, done, conflict;
  int tests = 0, fails = 0;
`ifdef SHIFT_DROP_CNT_EN
  logic [7:0] drop_count;
`endif
  shift_pulse_driver #(
    .CNT_W(32), .NORMAL_CYCLES(8), .NEUTRAL_CYCLES(4), .HOLDOFF_CYCLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .up_req(up_req), .down_req(down_req), .half(half),
    .abort(abort), .up_out(up_out), .down_out(down_out), .busy(busy), .done(done),
    .conflict(conflict)
`ifdef SHIFT_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    #12;
    chk("rst_up", up_out, 0); chk("rst_down", down_out, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_conflict", conflict, 0);
`ifdef SHIFT_DROP_CNT_EN
    chk("rst_drop", drop_count, 0);
`endif
    rst_n = 1'b1;
    tick();
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("n_up_on", up_out, 1); chk("n_down_off", down_out, 0);
      chk("n_busy", busy, 1); chk("n_done_low", done, 0);
      tick();
    end
    chk("n_up_end", up_out, 0); chk("n_done", done, 1); chk("n_hold_busy", busy, 1);
    tick();
    chk("n_done_once", done, 0); chk("n_hold_busy2", busy, 1);
    tick();
    chk("n_hold_busy3", busy, 1);
    tick();
    chk("n_idle", busy, 0); chk("n_down_never", down_out, 0);
    half = 1'b1; down_req = 1'b1;
    tick();
    half = 1'b0; down_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("h_down_on", down_out, 1); chk("h_up_off", up_out, 0); chk("h_done_low", done, 0);
      tick();
    end
    chk("h_down_end", down_out, 0); chk("h_done", done, 1);
    for (int k = 2; k <= 3; k++) begin
      tick();
      chk("h_hold_busy", busy, 1); chk("h_done_once", done, 0);
    end
    tick();
    chk("h_idle", busy, 0);
    up_req = 1'b1; down_req = 1'b1;
    tick();
    up_req = 1'b0; down_req = 1'b0;
    chk("c_conflict", conflict, 1); chk("c_busy", busy, 0);
    chk("c_up", up_out, 0); chk("c_down", down_out, 0);
    tick();
    chk("c_conflict_once", conflict, 0); chk("c_busy2", busy, 0); chk("c_up2", up_out, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0); chk("idle_abort_done", done, 0);
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("d_up_on", up_out, 1); chk("d_down_off", down_out, 0);
      down_req = (k == 3);
      tick();
      down_req = 1'b0;
    end
    chk("d_done", done, 1); chk("d_down_off2", down_out, 0);
    tick();
    down_req = 1'b1;
    tick();
    down_req = 1'b0;
    chk("d_hold_down_off", down_out, 0); chk("d_hold_busy", busy, 1);
    tick();
    chk("d_idle", busy, 0); chk("d_not_queued", down_out, 0);
    tick();
    chk("d_not_queued2", down_out, 0); chk("d_idle2", busy, 0);
`ifdef SHIFT_DROP_CNT_EN
    chk("d_drop_count", drop_count, 2);
`endif
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("a_up_on", up_out, 1);
      abort = (k == 5);
      tick();
      abort = 1'b0;
    end
    chk("a_up_off", up_out, 0); chk("a_done", done, 1); chk("a_busy", busy, 1);
    tick();
    chk("a_hold1", busy, 1); chk("a_done_once", done, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_hold2", busy, 1); chk("a_hold_abort_done", done, 0);
    tick();
    chk("a_idle", busy, 0);
    up_req = 1'b1;
    tick();
    up_req = 1'b0;
    chk("a_new_up", up_out, 1); chk("a_new_busy", busy, 1);
    tick();
    tick();
    chk("r_pre_up", up_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_up", up_out, 0); chk("r_async_busy", busy, 0); chk("r_async_done", done, 0);
`ifdef SHIFT_DROP_CNT_EN
    chk("r_drop_clear", drop_count, 0);
`endif
    #2 rst_n = 1'b1;
    tick();
    chk("r_idle", busy, 0); chk("r_idle_up", up_out, 0);
    down_req = 1'b1;
    tick();
    down_req = 1'b0;
    chk("r_accept_down", down_out, 1); chk("r_accept_busy", busy, 1); chk("r_accept_up", up_out, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
